// File: rtl/imem_boot_arbiter.sv
// Instruction-memory port owner: shares one port between loader writes and
// core fetch, sequences boot (LOAD->FLUSH->RUN->HALTED), parks core on HALT.
// Ports: clk/rst (async, active high); loader wr_valid/wr_addr/wr_data/start;
// core fetch_req/fetch_addr -> fetch_gnt/fetch_rvalid/fetch_rdata;
// memory mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata; core_rst/core_halt;
// sticky wbuf_overflow/write_dropped.
// Option: define IMEM_RUN_WRITE_EN to accept loader writes while running.
module imem_boot_arbiter #(
  parameter int          ADDR_W       = 32,
  parameter int          WBUF_DEPTH   = 4,
  parameter int          FLUSH_CYCLES = 4,
  parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              start,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              core_rst,
  output logic              core_halt,
  output logic              wbuf_overflow,
  output logic              write_dropped
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = $clog2(FLUSH_CYCLES + 1) + 1;

  typedef enum logic [1:0] {
    S_LOAD, S_FLUSH, S_RUN, S_HALTED
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] fa_q [WBUF_DEPTH];
  logic [31:0]       fd_q [WBUF_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [PW:0]       cnt_q, cnt_d;
  logic [CW-1:0]     fc_q, fc_d;
  logic              start_q;
  logic              rvalid_q;
  logic              core_rst_q;
  logic              ovf_q, drop_q;

  logic run, policy_ok, fifo_empty, fifo_full;
  logic deq, enq_try, enq, start_rise, flush_done;

  assign run        = (state_q == S_RUN);
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (PW+1)'(WBUF_DEPTH));
  assign start_rise = start & ~start_q;

`ifdef IMEM_RUN_WRITE_EN
  assign policy_ok = 1'b1;
`else
  assign policy_ok = ~run;
`endif

  // Fetch owns the port whenever granted; the FIFO takes every other cycle.
  assign deq     = ~fifo_empty & ~fetch_gnt;
  assign enq_try = wr_valid & policy_ok;
  assign enq     = enq_try & (~fifo_full | deq);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Idle count restarts whenever anything is still queued.
  always_comb begin
    fc_d = '0;
    if (state_q == S_FLUSH && fifo_empty)
      fc_d = fc_q + 1'b1;
  end

  assign flush_done = fifo_empty & ~enq &
                      (fc_q == CW'(FLUSH_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:   if (start_rise) state_d = S_FLUSH;
      S_FLUSH:  if (flush_done) state_d = S_RUN;
      S_RUN:
        if (rvalid_q && mem_rdata == HALT_INSTR)
          state_d = S_HALTED;
      S_HALTED:
        if (wr_valid)        state_d = S_LOAD;
        else if (start_rise) state_d = S_FLUSH;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    fetch_gnt = fetch_req & run;
    core_halt = (state_q == S_HALTED);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_gnt) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr;
    end else if (deq) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = fa_q[rp_q];
      mem_wdata = fd_q[rp_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      fc_q       <= '0;
      start_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      core_rst_q <= 1'b1;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      if (enq) wp_q <= wp_q + 1'b1;
      if (deq) rp_q <= rp_q + 1'b1;
      cnt_q      <= cnt_d;
      fc_q       <= fc_d;
      start_q    <= start;
      rvalid_q   <= fetch_gnt;
      core_rst_q <= (state_q == S_LOAD) | (state_q == S_FLUSH);
      if (enq_try & fifo_full & ~deq) ovf_q  <= 1'b1;
      if (wr_valid & ~policy_ok)      drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fa_q[wp_q] <= wr_addr;
      fd_q[wp_q] <= wr_data;
    end
  end

  assign fetch_rvalid  = rvalid_q;
  assign fetch_rdata   = rvalid_q ? mem_rdata : '0;
  assign core_rst      = core_rst_q;
  assign wbuf_overflow = ovf_q;
  assign write_dropped = drop_q;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Scoreboard bench for imem_boot_arbiter: expected memory writes and fetch
// data are queued by stimulus and popped by a negedge monitor.
module tb_imem_boot_arbiter;

  localparam int FC = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          start;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt, fetch_rvalid;
  logic [31:0]   fetch_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          core_rst, core_halt;
  logic          wbuf_overflow, write_dropped;

  imem_boot_arbiter #(
    .ADDR_W(AW), .WBUF_DEPTH(4),
    .FLUSH_CYCLES(FC), .HALT_INSTR(32'hFFFF_FFFF)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
    .fetch_rdata(fetch_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_rst(core_rst), .core_halt(core_halt),
    .wbuf_overflow(wbuf_overflow), .write_dropped(write_dropped)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_model [64];
  initial for (int i = 0; i < 64; i++) mem_model[i] = '0;

  always @(posedge clk) begin
    if (mem_en && mem_we)  mem_model[mem_addr[7:2]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem_model[mem_addr[7:2]];
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] rq[$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_en && mem_we) begin
      if (wq.size() == 0) begin
        chk("unexpected_mem_write", mem_addr, 32'hDEAD_BEEF);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("mem_write_addr", mem_addr, w.a);
        chk("mem_write_data", mem_wdata, w.d);
      end
    end
    if (fetch_rvalid) begin
      if (rq.size() == 0)
        chk("unexpected_rvalid", fetch_rdata, 32'hDEAD_BEEF);
      else
        chk("fetch_rdata", fetch_rdata, rq.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, bit expect_wr);
    wr_t w;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    w.a = a;
    w.d = d;
    if (expect_wr) wq.push_back(w);
  endtask

  task automatic fetch(logic [31:0] a, logic [31:0] exp);
    fetch_req  = 1'b1;
    fetch_addr = a;
    rq.push_back(exp);
  endtask

  task automatic wait_rst(logic v, string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (core_rst !== v && n < 60);
    chk(name, {31'b0, core_rst}, {31'b0, v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; wr_valid = 0; wr_addr = '0; wr_data = '0;
    start = 0; fetch_req = 1'b1; fetch_addr = '0;

    repeat (2) cyc();
    @(negedge clk);
    chk("rst_core_rst", {31'b0, core_rst}, 32'd1);
    chk("rst_core_halt", {31'b0, core_halt}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_fetch_gnt", {31'b0, fetch_gnt}, 32'd0);
    chk("rst_rvalid", {31'b0, fetch_rvalid}, 32'd0);
    chk("rst_flags", {30'b0, wbuf_overflow, write_dropped}, 32'd0);

    cyc(); rst = 1'b0; fetch_req = 1'b0;

    // Boot load of three words, then start.
    cyc(); wr(32'h0, 32'h13, 1);
    cyc(); wr(32'h4, 32'h13, 1);
    cyc(); wr(32'h8, 32'hFFFF_FFFF, 1);
    cyc(); wr_valid = 0; start = 1'b1;
    // FIFO empties at the next cycle; release lands FC+1 cycles later.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (core_rst !== 1'b0 && n < 60);
    chk("release_latency", n, FC + 3);

    // Fetch until the HALT word, with one read still in flight.
    cyc(); fetch(32'h0, 32'h13);
    @(negedge clk);
    chk("fetch_gnt", {31'b0, fetch_gnt}, 32'd1);
    chk("fetch_mem_we", {31'b0, mem_we}, 32'd0);
    chk("fetch_mem_en", {31'b0, mem_en}, 32'd1);
    cyc(); fetch(32'h8, 32'hFFFF_FFFF);
    cyc(); fetch(32'h4, 32'h13);
    @(negedge clk);
    chk("halt_not_yet", {31'b0, core_halt}, 32'd0);
    cyc(); fetch_req = 1'b1; fetch_addr = 32'h0;
    @(negedge clk);
    chk("halted_gnt", {31'b0, fetch_gnt}, 32'd0);
    chk("halted_halt", {31'b0, core_halt}, 32'd1);
    chk("halted_mem_en", {31'b0, mem_en}, 32'd0);
    chk("halted_core_rst", {31'b0, core_rst}, 32'd0);
    cyc(); fetch_req = 1'b0; start = 1'b0;

    // Rerun from HALTED via a fresh start rise.
    cyc(); start = 1'b1;
    wait_rst(1'b1, "rerun_rst_high");
    wait_rst(1'b0, "rerun_rst_low");

`ifdef IMEM_RUN_WRITE_EN
    for (int i = 0; i < 5; i++) begin
      cyc();
      fetch(32'h0, 32'h13);
      wr(32'h40 + 4 * i, 32'hA0 + i, i < 4);
    end
    cyc(); wr_valid = 0; fetch_req = 0;
    @(negedge clk);
    chk("run_overflow", {31'b0, wbuf_overflow}, 32'd1);
    chk("run_no_drop", {31'b0, write_dropped}, 32'd0);
    repeat (6) cyc();
`else
    cyc(); wr(32'h40, 32'hA5, 0);
    @(negedge clk);
    chk("drop_mem_en", {31'b0, mem_en}, 32'd0);
    cyc(); wr_valid = 0;
    @(negedge clk);
    chk("run_dropped", {31'b0, write_dropped}, 32'd1);
    chk("run_no_ovf", {31'b0, wbuf_overflow}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fifo_stays_empty", {31'b0, mem_en}, 32'd0);
    end
`endif

    // Halt again, then a loader write returns to LOAD.
    cyc(); fetch(32'h8, 32'hFFFF_FFFF);
    cyc(); fetch_req = 0;
    cyc();
    @(negedge clk);
    chk("halt2", {31'b0, core_halt}, 32'd1);
    cyc(); wr(32'h0, 32'h55, 1); start = 1'b0;
    cyc(); wr_valid = 0;
    @(negedge clk);
    chk("load_halt_clr", {31'b0, core_halt}, 32'd0);
    chk("load_rst_lag", {31'b0, core_rst}, 32'd0);
    cyc();
    @(negedge clk);
    chk("load_core_rst", {31'b0, core_rst}, 32'd1);

    // Async reset while FLUSH still has a queued word.
    cyc(); wr(32'h20, 32'h11, 1);
    cyc(); wr(32'h24, 32'h22, 0); start = 1'b1;
    cyc(); rst = 1'b1; wr_valid = 0; start = 0;
    @(negedge clk);
    chk("arst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("arst_core_rst", {31'b0, core_rst}, 32'd1);
    chk("arst_halt", {31'b0, core_halt}, 32'd0);
    cyc(); cyc(); rst = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    chk("post_rst_core_rst", {31'b0, core_rst}, 32'd1);
    chk("post_rst_flags", {30'b0, wbuf_overflow, write_dropped}, 32'd0);

    chk("wq_drained", wq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
